// File: rtl/output_sram_pkg.sv
// Shared types and sizing for the OUTPUT_SRAM controller: geometry, FSM states and
// requester ids for the round-robin pointer.
package output_sram_pkg;

  localparam int unsigned OSRAM_ADDR_W = 9;
  localparam int unsigned OSRAM_DATA_W = 32;
  localparam int unsigned OSRAM_DEPTH  = 512;

  typedef enum logic [0:0] {
    IDLE,
    ACC_WR
  } osram_state_e;

  typedef enum logic [0:0] {
    ReqWr,
    ReqRd
  } osram_req_e;

endpackage

// File: rtl/output_sram_ctrl_if.sv
// Requester handshakes plus OUTPUT_SRAM macro pins. The master side is the requesters and
// the macro; the slave side is the controller.
interface output_sram_ctrl_if #(
  parameter int unsigned ADDR_W = output_sram_pkg::OSRAM_ADDR_W,
  parameter int unsigned DATA_W = output_sram_pkg::OSRAM_DATA_W
) ();

  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_acc;
  logic              rd_valid;
  logic              rd_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_data_valid;
  logic              busy;
  logic              sram_cs;
  logic              sram_web;
  logic              sram_oe;
  logic [ADDR_W-1:0] sram_a;
  logic [DATA_W-1:0] sram_di;
  logic [DATA_W-1:0] sram_do;

  modport master (
    output wr_valid, wr_addr, wr_data, wr_acc, rd_valid, rd_addr, sram_do,
    input  wr_ready, rd_ready, rd_data, rd_data_valid, busy,
    input  sram_cs, sram_web, sram_oe, sram_a, sram_di
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, wr_acc, rd_valid, rd_addr, sram_do,
    output wr_ready, rd_ready, rd_data, rd_data_valid, busy,
    output sram_cs, sram_web, sram_oe, sram_a, sram_di
  );

endinterface

// File: rtl/output_sram_rr_arb.sv
// Two-way round-robin arbiter: combinational grant, registered pointer naming the side
// that wins the next tie.
module output_sram_rr_arb
  import output_sram_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req_wr,
  input  logic req_rd,
  output logic gnt_wr,
  output logic gnt_rd
);

  osram_req_e prio_q, prio_d;

  always_comb begin
    gnt_wr = 1'b0;
    gnt_rd = 1'b0;
    if (en) begin
      if (req_wr && req_rd) begin
        gnt_wr = (prio_q == ReqWr);
        gnt_rd = (prio_q == ReqRd);
      end else begin
        gnt_wr = req_wr;
        gnt_rd = req_rd;
      end
    end
  end

  always_comb begin
    prio_d = prio_q;
    if (gnt_wr) begin
      prio_d = ReqRd;
    end else if (gnt_rd) begin
      prio_d = ReqWr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q <= ReqWr;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/output_sram_ctrl.sv
// Shares one OUTPUT_SRAM macro between accelerator write-back and DMA read-out.
// Define OUTPUT_SRAM_CTRL_ACC_EN to enable in-place read-modify-write accumulation.
module output_sram_ctrl
  import output_sram_pkg::*;
#(
  parameter int unsigned ADDR_W = OSRAM_ADDR_W,
  parameter int unsigned DATA_W = OSRAM_DATA_W
) (
  input logic               clk,
  input logic               rst,
  output_sram_ctrl_if.slave bus
);

  logic              gnt_wr, gnt_rd, arb_en;
  logic              wr_ready, rd_ready, cs, web;
  logic [ADDR_W-1:0] a, a_q;
  logic [DATA_W-1:0] di, di_q;
  logic              oe_q, rd_data_valid_q;

`ifdef OUTPUT_SRAM_CTRL_ACC_EN
  osram_state_e      state_q, state_d;
  logic              acc_start, in_acc_wr;
  logic [ADDR_W-1:0] acc_addr_q;
  logic [DATA_W-1:0] acc_data_q;

  assign in_acc_wr = (state_q == ACC_WR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (acc_start) state_d = ACC_WR;
      ACC_WR:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_addr_q <= '0;
      acc_data_q <= '0;
    end else if (acc_start) begin
      acc_addr_q <= bus.wr_addr;
      acc_data_q <= bus.wr_data;
    end
  end

  // Reset gates grants so nothing handshakes while rst is held.
  assign arb_en = ~rst & ~in_acc_wr;
`else
  assign arb_en = ~rst;
`endif

  output_sram_rr_arb u_arb (
    .clk    (clk),
    .rst    (rst),
    .en     (arb_en),
    .req_wr (bus.wr_valid),
    .req_rd (bus.rd_valid),
    .gnt_wr (gnt_wr),
    .gnt_rd (gnt_rd)
  );

  always_comb begin
    wr_ready = 1'b0;
    rd_ready = 1'b0;
    cs       = 1'b0;
    web      = 1'b1;
    a        = a_q;
    di       = di_q;
`ifdef OUTPUT_SRAM_CTRL_ACC_EN
    acc_start = 1'b0;
    if (in_acc_wr) begin
      // Macro output holds the word read last cycle; sum wraps modulo 2^DATA_W.
      cs       = 1'b1;
      web      = 1'b0;
      a        = acc_addr_q;
      di       = bus.sram_do + acc_data_q;
      wr_ready = 1'b1;
    end else
`endif
    if (gnt_wr) begin
`ifdef OUTPUT_SRAM_CTRL_ACC_EN
      if (bus.wr_acc) begin
        cs        = 1'b1;
        a         = bus.wr_addr;
        acc_start = 1'b1;
      end else
`endif
      begin
        cs       = 1'b1;
        web      = 1'b0;
        a        = bus.wr_addr;
        di       = bus.wr_data;
        wr_ready = 1'b1;
      end
    end else if (gnt_rd) begin
      cs       = 1'b1;
      a        = bus.rd_addr;
      rd_ready = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q             <= '0;
      di_q            <= '0;
      oe_q            <= 1'b0;
      rd_data_valid_q <= 1'b0;
    end else begin
      a_q             <= a;
      di_q            <= di;
      oe_q            <= 1'b1;
      rd_data_valid_q <= gnt_rd;
    end
  end

  assign bus.wr_ready      = wr_ready;
  assign bus.rd_ready      = rd_ready;
  assign bus.sram_cs       = cs;
  assign bus.sram_web      = web;
  assign bus.sram_a        = a;
  assign bus.sram_di       = di;
  assign bus.sram_oe       = oe_q;
  assign bus.rd_data_valid = rd_data_valid_q;
  assign bus.rd_data       = bus.sram_do;
`ifdef OUTPUT_SRAM_CTRL_ACC_EN
  assign bus.busy          = gnt_wr | gnt_rd | in_acc_wr;
`else
  assign bus.busy          = gnt_wr | gnt_rd;
`endif

endmodule
